sram_bus_master: RTL
====================

# sram_bus_master

Synchronous initiator for the asynchronous SRAM-style peripheral bus (ncs/nwe/noe, 3-bit addr, 8-bit bidirectional data) used by the FPGA register-mapped peripherals. It turns a single-cycle request from on-chip logic into a correctly sequenced read or write bus cycle with programmable setup, strobe and hold lengths. It sits on the master side of that bus, so on-FPGA logic or test harnesses can drive the UART and similar peripherals without the external CPU.

## Interface
- ADDR_W, 3, bus address width
- DATA_W, 8, bus data width
- SETUP_CYC, 1, cycles ncs and addr are valid before the strobe; legal range 1..15
- STROBE_CYC, 3, cycles nwe/noe are held low; legal range 3..15, because peripherals sample on the falling edge and then register
- HOLD_CYC, 1, cycles ncs, addr and write data remain after the strobe; legal range 1..15

Ports:
- clk  in  1  single system clock; all logic is on posedge
- reset  in  1  asynchronous, active-high
- req  in  1  start a bus cycle; sampled only when busy=0
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- busy  out  1  a cycle is in progress
- done  out  1  one-cycle pulse when the bus cycle completes
- rdata  out  DATA_W  read data; holds its value until the next read completes
- addr  out  ADDR_W  bus address
- sram_data  inout  DATA_W  bus data; driven only during write cycles, otherwise high-Z
- ncs  out  1  chip select, active-low
- nwe  out  1  write strobe, active-low
- noe  out  1  output enable, active-low

## Operation
- All bus outputs, busy, done and rdata are registered. No combinational path exists from req to the bus.
- Reset values: ncs=1, nwe=1, noe=1, sram_data=Z, addr=0, busy=0, done=0, rdata=0, state=IDLE.
- The FSM has four states: IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter times each phase.
- IDLE
  - ncs, nwe and noe are all 1.
  - On req=1 the block latches req_we, req_addr and req_wdata and goes to SETUP with busy=1.
- SETUP
  - ncs=0 and addr is driven.
  - For a write, sram_data is driven with the latched data.
  - nwe=noe=1.
  - Lasts SETUP_CYC cycles, then goes to STROBE.
- STROBE
  - A write drives nwe=0; a read drives noe=0 and leaves sram_data at Z.
  - Lasts STROBE_CYC cycles.
  - For a read, rdata captures sram_data on the posedge that ends the last strobe cycle.
- HOLD
  - nwe=noe=1; ncs=0, addr and write data are unchanged.
  - Lasts HOLD_CYC cycles, then goes to IDLE.
- Return to IDLE: ncs=1, sram_data=Z, busy=0, done=1 for exactly one cycle.
- req while busy=1 is ignored; it is neither queued nor flagged.
- nwe and noe are never both 0. Write data never changes while ncs=0.

## Timing
- Latency: req is sampled at edge E0. ncs falls after E0. done is high in the cycle after edge E0+SETUP_CYC+STROBE_CYC+HOLD_CYC. With defaults, ncs is low for 5 cycles and done is seen after E5.
- Back-to-back: req may be held high. It is accepted at the edge where done is high (busy=0), so ncs is high for at least 1 cycle between transactions. Peripherals need this to re-arm write detection.
- Throughput: one transaction per SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
- Reset mid-cycle: asynchronous return to reset values at any state. No done pulse is generated, and sram_data is released immediately.
- Boundary values: the all-15 counter maximums give 45 cycles with ncs low. Addr 7 and data 0xFF/0x00 pass unmodified.

## Test plan
- Default-parameter write of 0xA5 to addr 5 -> ncs low 5 cycles; nwe low for cycles 2-4; sram_data=0xA5 throughout ncs low; noe stays 1; done pulses once at cycle 6; the bus model records (5, 0xA5).
- Read of addr 2 with a bus model driving 0x3C while ncs=0 and noe=0 -> rdata=0x3C at done; sram_data never driven by the DUT; rdata unchanged by a later write.
- req pulsed again at cycle 3 of an active write -> ignored; exactly one bus cycle and one done pulse.
- req held high with alternating write 0x11 to addr 1 and read of addr 1 -> ncs high exactly 1 cycle between transactions; read returns 0x11 from a loopback model.
- reset asserted mid-STROBE of a write -> ncs, nwe and noe go to 1 and sram_data to Z within the same cycle; no done pulse; the next req runs a full cycle normally.
- SETUP_CYC=2, STROBE_CYC=15, HOLD_CYC=3 -> nwe low exactly 15 cycles; ncs low 20 cycles; done after edge E20.

Source files
------------

// File: rtl/sram_bus_master.sv
// rtl/sram_bus_master.sv - registered initiator for the ncs/nwe/noe SRAM-style peripheral bus
module sram_bus_master #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              ncs,
  output logic              nwe,
  output logic              noe
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  // Each phase counter is loaded with length-1 and the phase ends when it reaches zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ncs_q, ncs_d;
  logic                nwe_q, nwe_d;
  logic                noe_q, noe_d;
  logic                drive_q, drive_d;

  // Next-state, phase timing and the next value of every registered bus output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STROBE_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Read data is taken on the edge that closes the strobe, while noe is still low.
          if (!we_q) rdata_d = sram_data;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they change exactly at phase boundaries.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_HOLD) && (state_d == S_IDLE);
    ncs_d   = (state_d == S_IDLE);
    nwe_d   = !((state_d == S_STROBE) && we_d);
    noe_d   = !((state_d == S_STROBE) && !we_d);
    drive_d = (state_d != S_IDLE) && we_d;
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ncs_q   <= 1'b1;
      nwe_q   <= 1'b1;
      noe_q   <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ncs_q   <= ncs_d;
      nwe_q   <= nwe_d;
      noe_q   <= noe_d;
      drive_q <= drive_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign addr      = addr_q;
  assign ncs       = ncs_q;
  assign nwe       = nwe_q;
  assign noe       = noe_q;
  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
